// File: rtl/interrupt_ctrl.sv
// Interrupt factor/request controller: per-source edge or level capture, masking,
// fixed-priority request encoding with CPU acknowledge, and savestate support.
module interrupt_ctrl #(
   parameter int                 NUM_SRC   = 8,
   parameter logic [NUM_SRC-1:0] FALL_EDGE = '1,
   parameter logic [NUM_SRC-1:0] LEVEL_SRC = '0,
   parameter logic [7:0]         SS_ADDR   = 8'h00
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               clk_en,
   input  logic [NUM_SRC-1:0] src_in,
   input  logic [NUM_SRC-1:0] src_mask,
   input  logic [NUM_SRC-1:0] factor_clr,
   input  logic               ack,
   output logic [NUM_SRC-1:0] factor,
   output logic               irq,
   output logic [3:0]         irq_id,
   input  logic [31:0]        ss_bus_in,
   input  logic [7:0]         ss_bus_addr,
   input  logic               ss_bus_wren,
   input  logic               ss_bus_reset_n,
   output logic [31:0]        ss_bus_out
);

   logic [NUM_SRC-1:0] prev_q, prev_d;
   logic [NUM_SRC-1:0] factor_q, factor_d;
   logic [31:0]        ss_data_q, ss_data_d;
   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] edge_ev;
   logic [NUM_SRC-1:0] clr;
   logic [3:0]         irq_id_c;
   logic [15:0]        prev_ext;
   logic [15:0]        factor_ext;

   // Savestate connector: holds the restore image, DEFAULT_VALUE is zero.
   always_comb begin
      ss_data_d = ss_data_q;
      if (!ss_bus_reset_n)
         ss_data_d = 32'h0;
      else if (ss_bus_wren && (ss_bus_addr == SS_ADDR))
         ss_data_d = ss_bus_in;
   end

   always_ff @(posedge clk) begin
      ss_data_q <= ss_data_d;
   end

   always_comb begin
      prev_ext                = '0;
      factor_ext              = '0;
      prev_ext[NUM_SRC-1:0]   = prev_q;
      factor_ext[NUM_SRC-1:0] = factor_q;
      ss_bus_out              = (ss_bus_addr == SS_ADDR) ? {prev_ext, factor_ext} : 32'h0;
   end

   // Lowest pending index wins; id stays 0 when nothing is pending.
   always_comb begin
      pending  = factor_q & src_mask;
      irq_id_c = 4'd0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (pending[i])
            irq_id_c = 4'(i);
      end
   end

   assign irq    = |pending;
   assign irq_id = irq_id_c;
   assign factor = factor_q;

   always_comb begin
      edge_ev = (FALL_EDGE & prev_q & ~src_in) | (~FALL_EDGE & ~prev_q & src_in);
      clr     = factor_clr;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (ack && irq && (irq_id_c == 4'(i)))
            clr[i] = 1'b1;
      end
   end

   // A set in the same cycle as a clear wins so that no event is dropped.
   always_comb begin
      prev_d   = prev_q;
      factor_d = factor_q;
      if (!reset_n) begin
         prev_d   = ss_data_q[16 +: NUM_SRC];
         factor_d = ss_data_q[0 +: NUM_SRC];
      end else if (clk_en) begin
         prev_d = src_in;
         for (int i = 0; i < NUM_SRC; i++) begin
            if (LEVEL_SRC[i])
               factor_d[i] = src_in[i];
            else if (edge_ev[i])
               factor_d[i] = 1'b1;
            else if (clr[i])
               factor_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      prev_q   <= prev_d;
      factor_q <= factor_d;
   end

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Bench for interrupt_ctrl: directed scenarios plus randomized traffic, all checked
// against a behavioural model of factor flags, request priority and savestate image.
module tb_interrupt_ctrl;

   localparam int         N    = 8;
   localparam logic [7:0] FALL = 8'hFE;
   localparam logic [7:0] LEVL = 8'h80;
   localparam logic [7:0] SSA  = 8'h3C;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        clk_en;
   logic [7:0]  src_in;
   logic [7:0]  src_mask;
   logic [7:0]  factor_clr;
   logic        ack;
   logic [7:0]  factor;
   logic        irq;
   logic [3:0]  irq_id;
   logic [31:0] ss_bus_in;
   logic [7:0]  ss_bus_addr;
   logic        ss_bus_wren;
   logic        ss_bus_reset_n;
   logic [31:0] ss_bus_out;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   logic [7:0]  m_prev   = 8'h0;
   logic [7:0]  m_factor = 8'h0;
   logic [31:0] m_ss     = 32'h0;

   always #5 clk = ~clk;

   interrupt_ctrl #(
      .NUM_SRC  (N),
      .FALL_EDGE(FALL),
      .LEVEL_SRC(LEVL),
      .SS_ADDR  (SSA)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .clk_en        (clk_en),
      .src_in        (src_in),
      .src_mask      (src_mask),
      .factor_clr    (factor_clr),
      .ack           (ack),
      .factor        (factor),
      .irq           (irq),
      .irq_id        (irq_id),
      .ss_bus_in     (ss_bus_in),
      .ss_bus_addr   (ss_bus_addr),
      .ss_bus_wren   (ss_bus_wren),
      .ss_bus_reset_n(ss_bus_reset_n),
      .ss_bus_out    (ss_bus_out)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [3:0] first_set(input logic [7:0] v);
      for (int i = 0; i < 8; i++)
         if (v[i]) return 4'(i);
      return 4'd0;
   endfunction

   task automatic compare_all(input string tag);
      logic [7:0] pend;
      pend = m_factor & src_mask;
      check_eq({tag, ".factor"}, 32'(factor), 32'(m_factor));
      check_eq({tag, ".irq"},    32'(irq),    32'(|pend));
      check_eq({tag, ".irq_id"}, 32'(irq_id), 32'(first_set(pend)));
      check_eq({tag, ".ss_out"}, ss_bus_out,
               (ss_bus_addr == SSA) ? {8'h0, m_prev, 8'h0, m_factor} : 32'h0);
   endtask

   // One clock: predict from pre-edge inputs/state, advance, then compare.
   task automatic cycle();
      logic [7:0]  nf, np, pend;
      logic [31:0] nss;
      logic        m_irq, hit;
      logic [3:0]  m_id;
      pend  = m_factor & src_mask;
      m_irq = |pend;
      m_id  = first_set(pend);
      nf = m_factor;
      np = m_prev;
      if (!reset_n) begin
         np = m_ss[23:16];
         nf = m_ss[7:0];
      end else if (clk_en) begin
         for (int i = 0; i < 8; i++) begin
            if (LEVL[i]) begin
               nf[i] = src_in[i];
            end else begin
               hit = FALL[i] ? (m_prev[i] && !src_in[i]) : (!m_prev[i] && src_in[i]);
               if (hit)
                  nf[i] = 1'b1;
               else if (factor_clr[i] || (ack && m_irq && (m_id == 4'(i))))
                  nf[i] = 1'b0;
            end
         end
         np = src_in;
      end
      nss = m_ss;
      if (!ss_bus_reset_n)
         nss = 32'h0;
      else if (ss_bus_wren && (ss_bus_addr == SSA))
         nss = ss_bus_in;
      @(posedge clk);
      #1;
      m_factor    = nf;
      m_prev      = np;
      m_ss        = nss;
      ack         = 1'b0;
      factor_clr  = 8'h0;
      ss_bus_wren = 1'b0;
      if (cmp_en) compare_all("model");
   endtask

   initial begin
      reset_n        = 1'b0;
      clk_en         = 1'b1;
      src_in         = 8'h7E;
      src_mask       = 8'hFF;
      factor_clr     = 8'h0;
      ack            = 1'b0;
      ss_bus_in      = 32'h0;
      ss_bus_addr    = SSA;
      ss_bus_wren    = 1'b0;
      ss_bus_reset_n = 1'b0;
      #1;
      cycle();
      ss_bus_reset_n = 1'b1;
      cycle();
      cmp_en = 1'b1;
      compare_all("reset");
      check_eq("reset.factor", 32'(factor), 32'h0);
      check_eq("reset.irq",    32'(irq),    32'h0);

      reset_n = 1'b1;
      cycle();
      check_eq("idle.factor", 32'(factor), 32'h0);

      // Falling edge on source 3, then its rising edge must not change anything.
      src_in[3] = 1'b0; cycle();
      check_eq("fall3.factor", 32'(factor), 32'h08);
      check_eq("fall3.irq",    32'(irq),    32'h1);
      check_eq("fall3.id",     32'(irq_id), 32'h3);
      src_in[3] = 1'b1; cycle();
      check_eq("rise3.factor", 32'(factor), 32'h08);
      factor_clr = 8'h08; cycle();
      check_eq("clr3.factor", 32'(factor), 32'h0);

      // Two pending sources served in priority order by ack.
      src_in[2] = 1'b0; src_in[5] = 1'b0; cycle();
      check_eq("two.factor", 32'(factor), 32'h24);
      check_eq("two.id",     32'(irq_id), 32'h2);
      src_in = 8'h7E; cycle();
      ack = 1'b1; cycle();
      check_eq("ack1.factor", 32'(factor), 32'h20);
      check_eq("ack1.id",     32'(irq_id), 32'h5);
      ack = 1'b1; cycle();
      check_eq("ack2.factor", 32'(factor), 32'h0);
      check_eq("ack2.irq",    32'(irq),    32'h0);
      ack = 1'b1; cycle();
      check_eq("ack_idle.factor", 32'(factor), 32'h0);

      // Masked source still latches; unmasking raises irq combinationally.
      src_mask = 8'h00;
      src_in[1] = 1'b0; cycle();
      check_eq("mask.factor", 32'(factor), 32'h02);
      check_eq("mask.irq",    32'(irq),    32'h0);
      src_in[1] = 1'b1; cycle();
      src_mask = 8'h02; #1;
      check_eq("unmask.irq", 32'(irq),    32'h1);
      check_eq("unmask.id",  32'(irq_id), 32'h1);
      factor_clr = 8'h02; cycle();
      src_mask = 8'hFF;

      // Set beats clear on the same cycle; clr alone clears; clk_en=0 freezes.
      src_in[4] = 1'b0; cycle();
      src_in[4] = 1'b1; cycle();
      src_in[4] = 1'b0; factor_clr = 8'h10; cycle();
      check_eq("setwins.factor", 32'(factor), 32'h10);
      src_in[4] = 1'b1; cycle();
      factor_clr = 8'h10; cycle();
      check_eq("clr4.factor", 32'(factor), 32'h0);
      src_in[4] = 1'b0; cycle();
      src_in[4] = 1'b1; cycle();
      clk_en = 1'b0; src_in[4] = 1'b0; factor_clr = 8'h10; ack = 1'b1; cycle();
      check_eq("hold.factor", 32'(factor), 32'h10);
      check_eq("hold.ss",     ss_bus_out, 32'h007E_0010);
      clk_en = 1'b1; src_in[4] = 1'b1; cycle();
      factor_clr = 8'h10; cycle();

      // Level source 7 follows the input and ignores ack.
      src_mask = 8'h80;
      src_in[7] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cycle();
         check_eq("level.f7", 32'(factor[7]), 32'h1);
      end
      check_eq("level.id", 32'(irq_id), 32'h7);
      ack = 1'b1; cycle();
      check_eq("level.ack", 32'(factor[7]), 32'h1);
      src_in[7] = 1'b0; cycle();
      check_eq("level.low", 32'(factor[7]), 32'h0);
      src_mask = 8'hFF;

      // Savestate restore through reset, with an ack discarded during reset.
      ss_bus_in = 32'h0000_0011; ss_bus_wren = 1'b1; cycle();
      reset_n = 1'b0; ack = 1'b1; cycle();
      check_eq("restore.factor", 32'(factor), 32'h11);
      check_eq("restore.id",     32'(irq_id), 32'h0);
      check_eq("restore.ss",     ss_bus_out,  32'h0000_0011);
      reset_n = 1'b1;
      ss_bus_addr = 8'h00; #1;
      check_eq("ss_other_addr", ss_bus_out, 32'h0);
      ss_bus_addr = SSA;

      // Randomized traffic against the model.
      for (int n = 0; n < 600; n++) begin
         reset_n        = ($urandom_range(0, 49) != 0);
         clk_en         = ($urandom_range(0, 4) != 0);
         src_in         = src_in ^ (8'($urandom) & 8'($urandom));
         if ($urandom_range(0, 9) == 0) src_mask = 8'($urandom);
         factor_clr     = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
         ack            = ($urandom_range(0, 2) == 0);
         ss_bus_reset_n = ($urandom_range(0, 99) != 0);
         ss_bus_wren    = ($urandom_range(0, 19) == 0);
         ss_bus_in      = $urandom;
         ss_bus_addr    = ($urandom_range(0, 3) != 0) ? SSA : 8'($urandom);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/interrupt_ctrl.md
Name: interrupt_ctrl

Overview:
- Parametrised interrupt factor/request controller for the CPU core. It is the generalised successor of the fixed clock/stopwatch/input interrupt logic.
- Supports NUM_SRC sources, each with a per-source edge or level mode, latched factor flags, masking, and a fixed-priority request encoder with a CPU acknowledge handshake.
- State is saved and restored over the savestate bus through the standard bus_connector.

Parameters:
NUM_SRC, 8, number of interrupt sources; legal range 1..16.
FALL_EDGE, all ones [NUM_SRC-1:0], per source: 1 = factor set on a falling edge, 0 = set on a rising edge.
LEVEL_SRC, 0 [NUM_SRC-1:0], per source: 1 = level source; the factor mirrors the sampled input and FALL_EDGE is ignored.
SS_ADDR, 8'h00, savestate bus address handed to bus_connector.

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
clk_en  in  1  CPU clock enable; state advances only when high
src_in  in  NUM_SRC  raw source signals, already synchronous to clk
src_mask  in  NUM_SRC  1 = source enabled to request
factor_clr  in  NUM_SRC  write-1-to-clear pulses for the factor flags (CPU factor-register read/clear)
ack  in  1  CPU interrupt acknowledge, single-cycle pulse
factor  out  NUM_SRC  latched factor flags
irq  out  1  interrupt request to the CPU
irq_id  out  4  index of the highest-priority pending source
ss_bus_in  in  32  savestate write data
ss_bus_addr  in  8  savestate address
ss_bus_wren  in  1  savestate write strobe
ss_bus_reset_n  in  1  savestate bus reset
ss_bus_out  out  32  savestate read data

Behaviour:
- Reset: reset_n is synchronous, active-low, on clock clk.
  - While reset_n=0: {prev_src, factor} <= ss_new_data from bus_connector, with DEFAULT_VALUE 0.
  - A cold reset therefore gives factor=0, prev_src=0, irq=0, irq_id=0.
  - A restore loads the saved values.
  - reset_n has priority over clk_en.
- Savestate packing: ss_current_data = {prev_src zero-extended to 16 bits, factor zero-extended to 16 bits}. Bits 31:16 hold prev_src and bits 15:0 hold factor. Unused bits read 0.
- No state changes when clk_en=0. All outputs hold.
- Per enabled cycle, for each edge source i:
  - Event when prev_src[i]=1 and src_in[i]=0 (FALL_EDGE[i]=1), or when prev_src[i]=0 and src_in[i]=1 (FALL_EDGE[i]=0).
  - On an event, factor[i] <= 1.
  - prev_src[i] <= src_in[i] every enabled cycle.
- Factor clear: factor[i] is cleared when factor_clr[i]=1, or when ack=1 with irq=1 and irq_id=i.
- Simultaneous event and clear on the same source in the same enabled cycle: the set wins and factor[i] ends at 1, so no event is lost.
- Level sources: factor[i] <= src_in[i] every enabled cycle. factor_clr and ack have no effect on them. prev_src is still tracked.
- Request encoding is combinational from registered state:
  - pending = factor & src_mask.
  - irq = |pending.
  - irq_id = lowest set index of pending (index 0 is highest priority); 0 when there is nothing pending.
- Latency:
  - An edge sampled in enabled cycle N gives factor/irq high from the next clk edge onward.
  - A mask change affects irq in the same cycle, because it is combinational.
- Ack handshake:
  - An ack while irq=0 is ignored.
  - An ack clears only the factor at the current irq_id.
  - Other pending sources re-present on the next cycle with the next-lowest index.
  - An ack while clk_en=0 is ignored; the CPU must hold ack until an enabled cycle.
- A masked source still latches its factor. Unmasking it later raises irq immediately.
- A reset in the middle of a pending request drops all state to ss_new_data. A pending ack in that cycle is discarded.

Test Plan:
- Cold reset, NUM_SRC=8, all falling-edge sources, src_in=8'hFF, mask=8'hFF. Drop src_in[3] to 0 for one enabled cycle -> factor=8'h08, irq=1, irq_id=3 one clk later; a rising edge on src_in[3] leaves factor unchanged.
- Set factor bits 2 and 5, pulse ack -> factor=8'h20, irq_id=5 next cycle; ack again -> factor=0, irq=0.
- mask=0, falling edge on src 1 -> factor=8'h02, irq=0; set mask=8'h02 -> irq=1, irq_id=1 in the same cycle.
- factor_clr[4] pulse coinciding with a new edge on src 4 -> factor[4] stays 1. A clr pulse alone -> factor[4]=0. With clk_en=0 during an edge and the clr pulse -> no change.
- LEVEL_SRC=8'h80, src_in[7] high for 3 enabled cycles -> factor[7]=1 for those cycles. An ack while irq_id=7 does not clear it. src_in[7] low -> factor[7]=0 next cycle.
- Write ss_bus 32'h0000_0011 at SS_ADDR, then assert reset_n=0 -> factor=8'h11, prev_src=0, irq_id=0. ss_bus_out reads back current_data = {prev_src, factor}.
